// File: rtl/stage2_product_sequencer_if.sv
// Stage-2 to stage-3 product interface: window/kernel handshake in, one-hot tagged product stream out.
// Master is the upstream window source and stage-3 consumer; slave is the product sequencer.
interface stage2_product_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int PROD_W = 2 * DATA_W
);
  logic                     window_valid;
  logic                     window_ready;
  logic [9*DATA_W-1:0]      pix_in;
  logic [9*DATA_W-1:0]      coef_in;
  logic                     stall;
  logic                     sum_done;
  logic                     start;
  logic signed [PROD_W-1:0] prod_data;
  logic                     prod1_valid;
  logic                     prod2_valid;
  logic                     prod3_valid;
  logic                     prod4_valid;
  logic                     prod5_valid;
  logic                     prod6_valid;
  logic                     prod7_valid;
  logic                     prod8_valid;
  logic                     prod9_valid;
  logic                     busy;
  logic                     seq_err;

  modport master (
    output window_valid, pix_in, coef_in, stall, sum_done,
    input  window_ready, start, prod_data,
    input  prod1_valid, prod2_valid, prod3_valid, prod4_valid, prod5_valid,
    input  prod6_valid, prod7_valid, prod8_valid, prod9_valid,
    input  busy, seq_err
  );

  modport slave (
    input  window_valid, pix_in, coef_in, stall, sum_done,
    output window_ready, start, prod_data,
    output prod1_valid, prod2_valid, prod3_valid, prod4_valid, prod5_valid,
    output prod6_valid, prod7_valid, prod8_valid, prod9_valid,
    output busy, seq_err
  );
endinterface

// File: rtl/stage2_product_sequencer.sv
// Latches a 3x3 window+kernel and streams its nine products one per unstalled cycle (first product the
// cycle after acceptance); stall freezes issue, and the next window is held off until stage 3 pulses sum_done.
module stage2_product_sequencer #(
  parameter int DATA_W = 8,
  parameter int PROD_W = 2 * DATA_W
) (
  input logic                       clk,
  input logic                       rst_n,
  stage2_product_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [DATA_W-1:0]        pix_q  [9];
  logic signed [DATA_W-1:0] coef_q [9];
  logic [3:0]               idx;
  logic [3:0]               idx_sel;
  logic signed [PROD_W-1:0] prod_q;
  logic signed [PROD_W-1:0] prod_nxt;
  logic signed [PROD_W-1:0] prod_first;
  logic                     seq_err_q;
  logic                     accept;
  logic                     issue;
  logic                     last;
  logic [8:0]               vld;

  // Unsigned pixel times signed coefficient, evaluated at full 2*DATA_W+1 precision.
  function automatic logic signed [PROD_W-1:0] mul(
    input logic [DATA_W-1:0]        p,
    input logic signed [DATA_W-1:0] c
  );
    logic signed [2*DATA_W:0] pe;
    logic signed [2*DATA_W:0] ce;
    logic signed [2*DATA_W:0] full;
    pe   = {{(DATA_W+1){1'b0}}, p};
    ce   = {{(DATA_W+1){c[DATA_W-1]}}, c};
    full = pe * ce;
    return PROD_W'(full);
  endfunction

  assign accept = (state == IDLE) && bus.window_valid && rst_n;
  assign issue  = (state == ISSUE) && !bus.stall;
  assign last   = issue && (idx == 4'd8);

  // prod_q is preloaded one issue ahead so each strobe meets a registered product.
  assign idx_sel    = (idx >= 4'd8) ? 4'd8 : idx + 4'd1;
  assign prod_nxt   = mul(pix_q[idx_sel], coef_q[idx_sel]);
  assign prod_first = mul(bus.pix_in[DATA_W-1:0], bus.coef_in[DATA_W-1:0]);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)       state_nxt = ISSUE;
      ISSUE:   if (last)         state_nxt = DRAIN;
      DRAIN:   if (bus.sum_done) state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < 9; i++) begin
        pix_q[i]  <= bus.pix_in[i*DATA_W +: DATA_W];
        coef_q[i] <= $signed(bus.coef_in[i*DATA_W +: DATA_W]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx       <= 4'd0;
      prod_q    <= '0;
      seq_err_q <= 1'b0;
    end else begin
      if (accept) begin
        idx    <= 4'd0;
        prod_q <= prod_first;
      end else if (issue) begin
        idx <= idx + 4'd1;
        if (!last) begin
          prod_q <= prod_nxt;
        end
      end
      // Early sum_done is flagged but never shortens the issue phase.
      if (bus.sum_done && (state != DRAIN)) begin
        seq_err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    vld = '0;
    if (issue) begin
      vld = 9'd1 << idx;
    end
  end

  assign bus.window_ready = (state == IDLE) && rst_n;
  assign bus.start        = (state == ISSUE);
  assign bus.busy         = (state != IDLE);
  assign bus.seq_err      = seq_err_q;
  assign bus.prod_data    = prod_q;
  assign bus.prod1_valid  = vld[0];
  assign bus.prod2_valid  = vld[1];
  assign bus.prod3_valid  = vld[2];
  assign bus.prod4_valid  = vld[3];
  assign bus.prod5_valid  = vld[4];
  assign bus.prod6_valid  = vld[5];
  assign bus.prod7_valid  = vld[6];
  assign bus.prod8_valid  = vld[7];
  assign bus.prod9_valid  = vld[8];

endmodule

// File: tb/tb_stage2_product_sequencer.sv
// Directed bench for stage2_product_sequencer: table of windows with hand-computed products plus stall,
// early sum_done and mid-issue reset sequences.
module tb_stage2_product_sequencer;

  typedef struct packed {
    logic [71:0]  pix;
    logic [71:0]  coef;
    logic [143:0] expv;
    int           sd_delay;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  bit   exp_err;
  vec_t vecs [4];

  stage2_product_sequencer_if #(.DATA_W(8), .PROD_W(16)) bus ();

  stage2_product_sequencer #(.DATA_W(8), .PROD_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  function automatic logic [71:0] p9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {a8[7:0], a7[7:0], a6[7:0], a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction

  function automatic logic [143:0] e9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {a8[15:0], a7[15:0], a6[15:0], a5[15:0], a4[15:0], a3[15:0], a2[15:0], a1[15:0], a0[15:0]};
  endfunction

  function automatic logic [15:0] get_vld();
    return {7'd0, bus.prod9_valid, bus.prod8_valid, bus.prod7_valid, bus.prod6_valid, bus.prod5_valid,
            bus.prod4_valid, bus.prod3_valid, bus.prod2_valid, bus.prod1_valid};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expct);
    checks++;
    if (act !== expct) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expct);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered mid-cycle with the DUT idle; leaves at the negedge of the cycle after sum_done.
  task automatic run_window(input vec_t v, input int stall_at, input int stall_len,
                            input int err_at, input int rst_at, input string nm);
    int k;
    int cyc;
    int stalled;
    bus.pix_in       = v.pix;
    bus.coef_in      = v.coef;
    bus.window_valid = 1'b1;
    #1;
    chk({nm, " ready"}, 16'(bus.window_ready), 16'd1);
    tick();
    // Changed operands and a stray window_valid during issue must be ignored.
    bus.pix_in  = ~v.pix;
    bus.coef_in = ~v.coef;
    k       = 0;
    cyc     = 0;
    stalled = 0;
    while (k < 9 && cyc < 40) begin
      if (k + 1 == rst_at) begin
        rst_n            = 1'b0;
        bus.window_valid = 1'b0;
        for (int r = 0; r < 2; r++) begin
          tick();
          chk($sformatf("%s rst%0d start", nm, r), 16'(bus.start), 16'd0);
          chk($sformatf("%s rst%0d vld", nm, r), get_vld(), 16'd0);
          chk($sformatf("%s rst%0d prod", nm, r), bus.prod_data, 16'd0);
          chk($sformatf("%s rst%0d busy", nm, r), 16'(bus.busy), 16'd0);
          chk($sformatf("%s rst%0d ready", nm, r), 16'(bus.window_ready), 16'd0);
          chk($sformatf("%s rst%0d err", nm, r), 16'(bus.seq_err), 16'd0);
        end
        rst_n   = 1'b1;
        exp_err = 1'b0;
        #1;
        chk({nm, " ready after rst"}, 16'(bus.window_ready), 16'd1);
        return;
      end
      bus.stall    = (k + 1 == stall_at) && (stalled < stall_len);
      bus.sum_done = (k + 1 == err_at) && !bus.stall;
      bus.window_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("%s c%0d start", nm, cyc), 16'(bus.start), 16'd1);
      chk($sformatf("%s c%0d busy", nm, cyc), 16'(bus.busy), 16'd1);
      if (bus.stall) begin
        chk($sformatf("%s c%0d stall vld", nm, cyc), get_vld(), 16'd0);
        stalled++;
      end else begin
        chk($sformatf("%s c%0d vld", nm, cyc), get_vld(), 16'd1 << k);
        chk($sformatf("%s c%0d prod", nm, cyc), bus.prod_data, v.expv[k*16 +: 16]);
        k++;
      end
      tick();
      cyc++;
    end
    bus.stall        = 1'b0;
    bus.sum_done     = 1'b0;
    bus.window_valid = 1'b0;
    if (k < 9) begin
      errors++;
      $display("FAIL %s issue timeout: got %0d products expected 9", nm, k);
    end
    for (int d = 0; d <= v.sd_delay; d++) begin
      bus.sum_done = (d == v.sd_delay);
      @(negedge clk);
      chk($sformatf("%s d%0d start", nm, d), 16'(bus.start), 16'd0);
      chk($sformatf("%s d%0d vld", nm, d), get_vld(), 16'd0);
      chk($sformatf("%s d%0d prod", nm, d), bus.prod_data, v.expv[128 +: 16]);
      chk($sformatf("%s d%0d busy", nm, d), 16'(bus.busy), 16'd1);
      chk($sformatf("%s d%0d ready", nm, d), 16'(bus.window_ready), 16'd0);
      chk($sformatf("%s d%0d err", nm, d), 16'(bus.seq_err), 16'(exp_err));
      tick();
    end
    bus.sum_done = 1'b0;
    @(negedge clk);
    chk({nm, " ready after done"}, 16'(bus.window_ready), 16'd1);
    chk({nm, " idle after done"}, 16'(bus.busy), 16'd0);
    chk({nm, " err after done"}, 16'(bus.seq_err), 16'(exp_err));
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_err = 1'b0;

    vecs[0].pix      = p9(1, 2, 3, 4, 5, 6, 7, 8, 9);
    vecs[0].coef     = p9(1, 1, 1, 1, 1, 1, 1, 1, 1);
    vecs[0].expv     = e9(1, 2, 3, 4, 5, 6, 7, 8, 9);
    vecs[0].sd_delay = 1;
    vecs[1].pix      = p9(255, 255, 255, 255, 255, 255, 255, 255, 255);
    vecs[1].coef     = p9(-128, -128, -128, -128, -128, -128, -128, -128, -128);
    vecs[1].expv     = e9(-32640, -32640, -32640, -32640, -32640, -32640, -32640, -32640, -32640);
    vecs[1].sd_delay = 0;
    vecs[2].pix      = p9(10, 20, 30, 40, 50, 60, 70, 80, 90);
    vecs[2].coef     = p9(-1, 2, -3, 4, -5, 6, -7, 8, -9);
    vecs[2].expv     = e9(-10, 40, -90, 160, -250, 360, -490, 640, -810);
    vecs[2].sd_delay = 0;
    vecs[3].pix      = p9(255, 0, 128, 1, 200, 255, 7, 100, 3);
    vecs[3].coef     = p9(127, -128, -1, -128, 0, -1, 100, -100, 127);
    vecs[3].expv     = e9(32385, 0, -128, -128, 0, -255, 700, -10000, 381);
    vecs[3].sd_delay = 2;

    rst_n            = 1'b0;
    bus.window_valid = 1'b1;
    bus.pix_in       = vecs[0].pix;
    bus.coef_in      = vecs[0].coef;
    bus.stall        = 1'b0;
    bus.sum_done     = 1'b0;
    for (int r = 0; r < 3; r++) begin
      tick();
      chk($sformatf("reset%0d start", r), 16'(bus.start), 16'd0);
      chk($sformatf("reset%0d vld", r), get_vld(), 16'd0);
      chk($sformatf("reset%0d prod", r), bus.prod_data, 16'd0);
      chk($sformatf("reset%0d busy", r), 16'(bus.busy), 16'd0);
      chk($sformatf("reset%0d err", r), 16'(bus.seq_err), 16'd0);
      chk($sformatf("reset%0d ready", r), 16'(bus.window_ready), 16'd0);
    end
    bus.window_valid = 1'b0;
    rst_n            = 1'b1;
    #1;
    chk("release ready", 16'(bus.window_ready), 16'd1);
    chk("release err", 16'(bus.seq_err), 16'd0);

    // Back-to-back windows; sd_delay = 0 exercises sum_done in the first drain cycle.
    for (int i = 0; i < 4; i++) begin
      run_window(vecs[i], 0, 0, 0, 0, $sformatf("vec%0d", i));
    end

    run_window(vecs[2], 4, 2, 0, 0, "stall");

    exp_err = 1'b1;
    vecs[0].sd_delay = 3;
    run_window(vecs[0], 0, 0, 5, 0, "early_done");
    run_window(vecs[1], 0, 0, 0, 0, "sticky_err");

    run_window(vecs[3], 0, 0, 0, 6, "mid_reset");
    vecs[0].sd_delay = 0;
    run_window(vecs[0], 0, 0, 0, 0, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage2_product_sequencer.md
# stage2_product_sequencer

Source side of the stage-2/stage-3 product interface in the 3x3 convolution datapath. The block accepts one 3x3 pixel window plus its 3x3 kernel and computes the nine pixel×coefficient products. It presents them on a single product bus, one per cycle, each tagged with a one-hot `prodN_valid` strobe and framed by `start`, which is what the stage-3 accumulator control consumes. It then holds off the next window until stage 3 signals that the sum is done.

## Interface
Parameters:
- `DATA_W`, 8, pixel and coefficient width.
- `PROD_W`, 2*DATA_W, product width. Signed. Must be ≥ 2*DATA_W.

Ports:
- `clk`  in  1  system clock. One clock; reset is synchronous and active-low.
- `rst_n`  in  1  synchronous active-low reset.
- `window_valid`  in  1  the window and kernel inputs are valid.
- `window_ready`  out  1  the block can accept a window.
- `pix_in`  in  9*DATA_W  unsigned pixels. Element i is at bits [i*DATA_W +: DATA_W], row-major, i = 0..8.
- `coef_in`  in  9*DATA_W  signed coefficients, same packing as `pix_in`.
- `stall`  in  1  pauses product issue for the current cycle.
- `sum_done`  in  1  one-cycle pulse from stage 3 (its `out_adder_valid` path) meaning the window sum has been taken.
- `start`  out  1  frame signal, high for the whole issue phase.
- `prod_data`  out  PROD_W  current product.
- `prod1_valid` … `prod9_valid`  out  1 each  one-hot tag for product index 0..8.
- `busy`  out  1  state is not IDLE.
- `seq_err`  out  1  sticky protocol-error flag.

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- **IDLE**
  - `window_ready` = 1 (gated by `rst_n`).
  - On `window_valid & window_ready`: register all 18 operands, clear index `idx` to 0, go to ISSUE.
- **ISSUE**
  - Each cycle with `stall` = 0:
    - `prod_data` <= zero-extended `pix[idx]` × signed `coef[idx]`, sign-extended to PROD_W.
    - Assert `prod{idx+1}_valid`.
    - `idx` increments.
  - After the `idx` = 8 issue, go to DRAIN.
  - While `stall` = 1: `idx` holds, all `prodN_valid` = 0, `prod_data` holds, `start` stays 1.
- **DRAIN**
  - `start` = 0, all valids = 0, `prod_data` holds its last value.
  - On `sum_done` = 1, return to IDLE.
- Arithmetic:
  - Each operand is computed as signed (DATA_W+1) × signed DATA_W.
  - For DATA_W = 8 the range is −32640..32385, with no overflow in 16 bits.
- At most one `prodN_valid` is high in any cycle. `prod9_valid` is asserted exactly once per window.
- Input side: `window_valid` while not ready is ignored, with no error. Operands are sampled only at acceptance, so input changes during ISSUE or DRAIN have no effect.
- `sum_done` in IDLE or ISSUE sets `seq_err`. That pulse is otherwise ignored and does not shorten ISSUE.
- `seq_err` clears only on reset.

## Timing
- Reset (`rst_n` = 0 at a rising edge), values from the next cycle:
  - State IDLE, `idx` = 0.
  - `start` = 0, all `prodN_valid` = 0, `prod_data` = 0, `busy` = 0, `seq_err` = 0.
  - `window_ready` = 0 while `rst_n` is low.
- Reset mid-ISSUE or mid-DRAIN discards the window. There are no further valids after the reset edge.
- Window accepted at edge T:
  - `start` and `prod1_valid` are high in cycle T+1.
  - `prodK_valid` is high in cycle T+K.
  - `start` falls at T+10 when there are no stalls.
  - Each stall cycle shifts all later strobes by one.
- `prod_data` is registered and valid in the same cycle as its strobe.
- `sum_done` sampled at edge D: state is IDLE and `window_ready` = 1 in cycle D+1. Earliest next acceptance is edge D+1.
- Minimum window period is 11 cycles: 9 issue cycles, ≥ 1 drain cycle, 1 accept cycle.
- `sum_done` may arrive in the first DRAIN cycle, which is the edge ending the `prod9` cycle. It must not be lost.
- `busy` = 1 from T+1 until the cycle after `sum_done`.

## Test plan
- Reset behaviour: hold `rst_n` = 0 for 3 cycles, then release. All outputs are 0 during reset. `window_ready` = 1 in the first cycle after release. `seq_err` = 0.
- Nominal sequence: pix = 1..9, coef = 1 for all elements, `sum_done` pulsed 2 cycles after `prod9_valid`.
  - `prod_data` = 1,2,…,9 on `prod1_valid`..`prod9_valid` in consecutive cycles.
  - `start` is high for exactly 9 cycles.
  - `window_ready` returns the cycle after `sum_done`.
- Sign and width: pix = 255 for all, coef = −128 for all. Every `prod_data` = −32640 (0x8080).
- Stall mid-sequence: assert `stall` for 2 cycles during the cycle where `prod4_valid` would be high.
  - `prod4_valid` is delayed 2 cycles.
  - No valid is high during the stall.
  - `start` stays high for 11 cycles total.
  - The product order is unchanged.
- Protocol error: pulse `sum_done` during ISSUE at `prod5`.
  - `seq_err` goes to 1 and stays there.
  - All 9 products are still issued.
  - The FSM stays in DRAIN until a second `sum_done`.
- Reset mid-operation: drive `rst_n` low in the `prod6` cycle. No further `prodN_valid`, `start` = 0, `prod_data` = 0 after the edge. A new window after release starts cleanly at `prod1`.
